spi_cmd_queue: RTL and testbench

//  Parametrised successor to the single-register SPI command generator. Accepts
//  32-bit host writes, splits each into register address + data, and buffers

---
 rtl/spi_cmd_queue.sv | 200 ++++++++++++++++++++
 tb/tb_spi_cmd_queue.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: buffers 32-bit host writes as {addr, data} commands and
// issues them one at a time to an SPI master over a valid/ready handshake.
// Latency: a write into an empty queue shows cmd_valid_o two cycles later.
// Backpressure: cmd_ready_i low holds the current command; when the FIFO is
// full, writes are dropped and counted in drop_cnt_o (saturating).
//
// Optional feature macro: SPI_CMD_DEDUP_EN
//   When it is defined, a write equal to the last word accepted into the FIFO
//   is ignored.
//
// Ports:
//   clk_i, rst_i          clock and async active-high reset
//   wren_i, indata_i      host write strobe and command word
//   full_o, level_o       FIFO full flag and occupancy (0..DEPTH)
//   cmd_valid_o/_ready_i  command handshake towards the SPI master
//   addr_o, sdata_o       current (or last issued) command fields
//   ctrlen_o              one-cycle pulse in the cycle after each handshake
//   drop_cnt_o            writes lost to a full FIFO, saturates at 8'hFF
module spi_cmd_queue #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_LSB = 16,
  parameter int DEPTH    = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wren_i,
  input  logic [31:0]              indata_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [DATA_W-1:0]        sdata_o,
  output logic                     ctrlen_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int GAP_W   = $clog2(GAP_CYC + 2);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  sdata_q;
  logic               ctrlen_q;
  logic [7:0]         drop_cnt_q;

  logic               dup;
  logic               push;
  logic               drop;
  logic               pop;
  logic               hs;
  logic [ENTRY_W-1:0] entry_in;

  assign entry_in = {indata_i[ADDR_LSB +: ADDR_W], indata_i[DATA_W-1:0]};

`ifdef SPI_CMD_DEDUP_EN
  logic [31:0] last_q;
  logic        last_vld_q;

  // Only words that actually enter the FIFO become the comparison reference.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= indata_i;
      last_vld_q <= 1'b1;
    end
  end

  assign dup = last_vld_q && (indata_i == last_q);
`else
  logic unused_indata;
  assign unused_indata = ^indata_i;
  assign dup = 1'b0;
`endif

  // A duplicate is silently ignored, so it neither writes nor counts as a drop.
  // A full FIFO rejects the write even if a pop happens in the same cycle.
  assign full_o = (level_q == LVL_W'(DEPTH));
  assign push   = wren_i && !dup && !full_o;
  assign drop   = wren_i && !dup && full_o;
  assign hs     = cmd_valid_o && cmd_ready_i;

  // FIFO storage carries no reset; only the pointers and level define content.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    gap_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (cmd_ready_i) state_d = (GAP_CYC > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_valid_o = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE:  pop         = (level_q != '0);
      S_ISSUE: cmd_valid_o = 1'b1;
      default: begin
        cmd_valid_o = 1'b0;
        pop         = 1'b0;
      end
    endcase
  end

  // Command fields load on pop and then hold, so they keep showing the last
  // issued command outside the ISSUE state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      sdata_q    <= '0;
      ctrlen_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (pop) begin
        {addr_q, sdata_q} <= mem_q[rd_ptr_q];
      end
      ctrlen_q <= hs;
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign level_o    = level_q;
  assign addr_o     = addr_q;
  assign sdata_o    = sdata_q;
  assign ctrlen_o   = ctrlen_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_spi_cmd_queue.sv
module tb_spi_cmd_queue;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int ADDR_LSB = 16;
  localparam int DEPTH    = 4;
  localparam int GAP_CYC  = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wren = 1'b0;
  logic [31:0]            indata = '0;
  logic                   full;
  logic [$clog2(DEPTH):0] level;
  logic                   cmd_valid;
  logic                   cmd_ready = 1'b0;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      sdata;
  logic                   ctrlen;
  logic [7:0]             drop_cnt;

  always #5 clk = ~clk;

  spi_cmd_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LSB(ADDR_LSB),
    .DEPTH(DEPTH), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wren_i(wren), .indata_i(indata),
    .full_o(full), .level_o(level), .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready), .addr_o(addr), .sdata_o(sdata),
    .ctrlen_o(ctrlen), .drop_cnt_o(drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: commands not yet handed to the SPI master, in write order.
  // While cmd_ready is low the block can hold DEPTH words in the FIFO plus the
  // one already popped into the issue slot.
  logic [31:0] exp_q[$];
  int          m_drop;
  logic [31:0] m_last;
  bit          m_last_vld;

`ifdef SPI_CMD_DEDUP_EN
  localparam int DEDUP_ON = 1;
`else
  localparam int DEDUP_ON = 0;
`endif

  function automatic logic [ADDR_W-1:0] f_addr(input logic [31:0] w);
    return w[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] f_data(input logic [31:0] w);
    return w[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_drop     = 0;
    m_last     = '0;
    m_last_vld = 0;
  endtask

  task automatic model_write(input logic [31:0] w);
    if (DEDUP_ON != 0 && m_last_vld && w == m_last) return;
    if (exp_q.size() == DEPTH + 1) begin
      if (m_drop < 255) m_drop++;
    end else begin
      exp_q.push_back(w);
      m_last     = w;
      m_last_vld = 1;
    end
  endtask

  task automatic dut_reset();
    @(negedge clk);
    rst       = 1'b1;
    wren      = 1'b0;
    cmd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs with cmd_ready high until every expected command has been seen,
  // checking order, fields, spacing and the ctrlen pulse each cycle.
  task automatic drain(output int n_hs);
    bit          prev_hs;
    bit          hs;
    int          last_cyc;
    int          tail;
    logic [31:0] w;
    n_hs      = 0;
    prev_hs   = 0;
    last_cyc  = -1;
    tail      = 0;
    wren      = 1'b0;
    cmd_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      checks++;
      if (ctrlen !== prev_hs) begin
        failures++;
        $display("FAIL drain_ctrlen cyc=%0d got=%b exp=%b", cyc, ctrlen, prev_hs);
      end
      hs = (cmd_valid === 1'b1);
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drain_extra_cmd got addr=%h sdata=%h exp none", addr, sdata);
        end else begin
          w = exp_q.pop_front();
          n_hs++;
          checks++;
          if (addr !== f_addr(w) || sdata !== f_data(w)) begin
            failures++;
            $display("FAIL drain_cmd got addr=%h sdata=%h exp addr=%h sdata=%h",
                     addr, sdata, f_addr(w), f_data(w));
          end
          if (last_cyc >= 0) begin
            checks++;
            if (cyc - last_cyc != GAP_CYC + 2) begin
              failures++;
              $display("FAIL drain_spacing got=%0d exp=%0d", cyc - last_cyc, GAP_CYC + 2);
            end
          end
          last_cyc = cyc;
        end
      end
      prev_hs = hs;
      if (exp_q.size() == 0 && !hs) tail++;
      if (tail > GAP_CYC + 3) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    dut_reset();
    checks++;
    if ({cmd_valid, ctrlen, full} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got v/c/f=%b%b%b exp=000", cmd_valid, ctrlen, full);
    end
    checks++;
    if (level !== '0 || drop_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_counts got level=%0d drop=%0d exp 0/0", level, drop_cnt);
    end
    checks++;
    if (addr !== '0 || sdata !== '0) begin
      failures++;
      $display("FAIL reset_fields got addr=%h sdata=%h exp 0/0", addr, sdata);
    end
  endtask

  task automatic test_reset_mid_issue();
    dut_reset();
    for (int i = 0; i < 6; i++) begin
      indata = $urandom;
      wren   = 1'b1;
      model_write(indata);
      @(negedge clk);
    end
    wren = 1'b0;
    checks++;
    if (cmd_valid !== 1'b1 || level !== 3'(DEPTH) || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL midrst_pre got valid=%b level=%0d drop=%0d exp 1/%0d/1",
               cmd_valid, level, drop_cnt, DEPTH);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_valid, ctrlen, full} !== 3'b000 || level !== '0 || drop_cnt !== 8'h00) begin
      failures++;
      $display("FAIL midrst got valid=%b ctrlen=%b full=%b level=%0d drop=%0d exp all 0",
               cmd_valid, ctrlen, full, level, drop_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    cmd_ready = 1'b1;
    indata    = 32'h0003_ABCD;
    wren      = 1'b1;
    model_write(indata);
    @(negedge clk);
    wren = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_lat1 got valid=%b exp=0", cmd_valid);
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || addr !== 4'h3 || sdata !== 16'hABCD) begin
      failures++;
      $display("FAIL single_issue got valid=%b addr=%h sdata=%h exp 1/3/abcd",
               cmd_valid, addr, sdata);
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || ctrlen !== 1'b1) begin
      failures++;
      $display("FAIL single_hs got valid=%b ctrlen=%b exp 0/1", cmd_valid, ctrlen);
    end
    @(negedge clk);
    checks++;
    if (ctrlen !== 1'b0 || addr !== 4'h3 || sdata !== 16'hABCD) begin
      failures++;
      $display("FAIL single_after got ctrlen=%b addr=%h sdata=%h exp 0/3/abcd",
               ctrlen, addr, sdata);
    end
    void'(exp_q.pop_front());
    repeat (GAP_CYC + 2) @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_full_drop();
    int n;
    for (int i = 0; i < 6; i++) begin
      indata = $urandom;
      wren   = 1'b1;
      model_write(indata);
      @(negedge clk);
    end
    wren = 1'b0;
    checks++;
    if (full !== 1'b1 || level !== 3'(DEPTH)) begin
      failures++;
      $display("FAIL full_state got full=%b level=%0d exp 1/%0d", full, level, DEPTH);
    end
    checks++;
    if (drop_cnt !== 8'(m_drop) || cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_drop got drop=%0d valid=%b exp %0d/1", drop_cnt, cmd_valid, m_drop);
    end
    drain(n);
    checks++;
    if (n != DEPTH + 1) begin
      failures++;
      $display("FAIL full_count got=%0d exp=%0d", n, DEPTH + 1);
    end
  endtask

  task automatic test_hold();
    int          n;
    logic [31:0] w;
    w      = $urandom;
    indata = w;
    wren   = 1'b1;
    model_write(w);
    @(negedge clk);
    wren = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || ctrlen !== 1'b0 || addr !== f_addr(w) || sdata !== f_data(w)) begin
        failures++;
        $display("FAIL hold cyc=%0d got valid=%b ctrlen=%b addr=%h sdata=%h exp 1/0/%h/%h",
                 i, cmd_valid, ctrlen, addr, sdata, f_addr(w), f_data(w));
      end
      @(negedge clk);
    end
    drain(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL hold_count got=%0d exp=1", n);
    end
  endtask

  task automatic test_dedup();
    int          n;
    logic [31:0] words [3];
    words[0] = 32'h0001_0005;
    words[1] = 32'h0001_0005;
    words[2] = 32'h0001_0006;
    dut_reset();
    for (int i = 0; i < 3; i++) begin
      indata = words[i];
      wren   = 1'b1;
      model_write(indata);
      @(negedge clk);
    end
    wren = 1'b0;
    drain(n);
    checks++;
    if (n != ((DEDUP_ON != 0) ? 2 : 3)) begin
      failures++;
      $display("FAIL dedup_count got=%0d exp=%0d", n, (DEDUP_ON != 0) ? 2 : 3);
    end
  endtask

  task automatic test_random();
    int          n;
    logic [31:0] prev;
    prev = $urandom;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 10; c++) begin
        wren = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) indata = prev;
        else indata = $urandom;
        if (wren) begin
          model_write(indata);
          prev = indata;
        end
        @(negedge clk);
      end
      wren = 1'b0;
      checks++;
      if (drop_cnt !== 8'(m_drop)) begin
        failures++;
        $display("FAIL random_drop round=%0d got=%0d exp=%0d", r, drop_cnt, m_drop);
      end
      drain(n);
    end
  endtask

  task automatic test_saturate();
    int          n;
    logic [31:0] r;
    dut_reset();
    for (int i = 0; i < 280; i++) begin
      r      = $urandom;
      indata = {16'(i), r[15:0]};
      wren   = 1'b1;
      model_write(indata);
      @(negedge clk);
      checks++;
      if (drop_cnt !== 8'(m_drop)) begin
        failures++;
        $display("FAIL sat_drop i=%0d got=%0d exp=%0d", i, drop_cnt, m_drop);
      end
    end
    wren = 1'b0;
    checks++;
    if (drop_cnt !== 8'hFF || full !== 1'b1) begin
      failures++;
      $display("FAIL sat_final got drop=%h full=%b exp ff/1", drop_cnt, full);
    end
    drain(n);
    checks++;
    if (n != DEPTH + 1 || drop_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL sat_drain got n=%0d drop=%h exp %0d/ff", n, drop_cnt, DEPTH + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_issue();
    test_single();
    test_full_drop();
    test_hold();
    test_dedup();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
